// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift unit.
// Rotate support is selected with the SHIFT_SEQ_ROT_EN macro.
package shift_pkg;

  localparam int SHIFT_WIDTH = 32;
  localparam int SHIFT_AMT_W = 5;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-position shift step; rotate arm exists only with SHIFT_SEQ_ROT_EN.
// Without the macro, op 11 falls through to the logical-right default.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = {1'b0, acc[WIDTH-1:1]};
    case (op)
      OP_SLL: nxt = {acc[WIDTH-2:0], 1'b0};
      OP_SRA: nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROT_EN
      OP_ROR: nxt = {acc[0], acc[WIDTH-1:1]};
`else
      OP_ROR: nxt = {1'b0, acc[WIDTH-1:1]};
`endif
      default: nxt = {1'b0, acc[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift unit: one bit position per clock, done pulse on result.
// Optional rotate-right is enabled by defining SHIFT_SEQ_ROT_EN.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int AMT_W = SHIFT_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc (acc),
    .op  (op_q),
    .nxt (acc_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == AMT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // done and out are registered, so they appear the cycle after DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= OP_SRL;
      out  <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) out <= acc;
      if (state == IDLE && start) begin
        acc  <= num;
        cnt  <= amt;
        op_q <= op;
      end else if (state == SHIFT) begin
        acc <= acc_step;
        cnt <= cnt - AMT_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: latency, busy span, results, ignore, reset.
// Expected rotate results follow the SHIFT_SEQ_ROT_EN build setting.
module tb_shift_seq;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num;
  logic [4:0]  amt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int vecs = 0;
  int errs = 0;

  shift_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .num   (num),
    .amt   (amt),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    vecs++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] n,
                     input logic [4:0] a, input logic [1:0] o,
                     input logic [31:0] exp_out, input bit poke);
    int k;
    int bcnt;
    bit seen;
    bit unstable;
    logic [31:0] prev;
    @(negedge clk);
    prev  = out;
    num   = n;
    amt   = a;
    op    = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    num   = 32'hA5A5_5A5A;
    amt   = 5'd3;
    op    = ~o;
    k = 0;
    bcnt = 0;
    seen = 0;
    unstable = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (busy) bcnt++;
      if (done) seen = 1;
      else if (out !== prev) unstable = 1;
      if (poke && k == 3) begin
        start = 1'b1;
        num   = 32'hFFFF_0000;
        amt   = 5'd1;
        op    = OP_SRL;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, k, a + 2);
    chk({tag, " busy_cycles"}, bcnt, a + 1);
    chk({tag, " out_stable"}, 32'(unstable), 32'd0);
    chk({tag, " out"}, out, exp_out);
    @(negedge clk);
    chk({tag, " done_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({tag, " out_hold"}, out, exp_out);
  endtask

  initial begin
    logic [31:0] ror1;
    logic [31:0] ror8;
    bit got_done;
`ifdef SHIFT_SEQ_ROT_EN
    ror1 = 32'h8000_0000;
    ror8 = 32'h7812_3456;
`else
    ror1 = 32'h0000_0000;
    ror8 = 32'h0012_3456;
`endif
    rst   = 1'b1;
    start = 1'b0;
    num   = '0;
    amt   = '0;
    op    = OP_SRL;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle", {busy, done, 30'd0}, 32'd0);
      chk("idle out", out, 32'd0);
    end

    run("sll4", 32'h0000_00F0, 5'd4, OP_SLL, 32'h0000_0F00, 0);
    run("sra31", 32'h8000_0000, 5'd31, OP_SRA, 32'hFFFF_FFFF, 0);
    run("srl31", 32'h8000_0000, 5'd31, OP_SRL, 32'h0000_0001, 0);
    run("amt0", 32'hDEAD_BEEF, 5'd0, OP_SRL, 32'hDEAD_BEEF, 0);
    run("ror1", 32'h0000_0001, 5'd1, OP_ROR, ror1, 0);
    run("ror8", 32'h1234_5678, 5'd8, OP_ROR, ror8, 0);
    run("sra4", 32'h8000_00F0, 5'd4, OP_SRA, 32'hF800_000F, 0);
    run("sra16", 32'h7FFF_FFFF, 5'd16, OP_SRA, 32'h0000_7FFF, 0);
    run("srl8", 32'hF000_000F, 5'd8, OP_SRL, 32'h00F0_0000, 0);
    run("sll31", 32'h1234_5679, 5'd31, OP_SLL, 32'h8000_0000, 0);
    run("poke", 32'h0000_1234, 5'd8, OP_SLL, 32'h0012_3400, 1);
    repeat (4) begin
      @(negedge clk);
      chk("no_queue", {30'd0, done, busy}, 32'd0);
    end

    @(negedge clk);
    num   = 32'h0000_00FF;
    amt   = 5'd8;
    op    = OP_SLL;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst async", {busy, done, 30'd0}, 32'd0);
    chk("rst out", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    got_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) got_done = 1;
    end
    chk("rst no_done", 32'(got_done), 32'd0);
    chk("rst out_after", out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle sequential shift unit for the datapath's shift/rotate instructions. It accepts a 32-bit operand, a 5-bit amount and an operation code on a start pulse, then shifts one bit position per clock. It reports the result with a one-cycle `done` pulse. It sits beside the ALU as a low-area alternative to a combinational barrel shifter, and adds arithmetic-right and optional rotate operations.

## Interface
- `WIDTH`, 32, operand/result width
- `AMT_W`, 5, shift-amount width (log2 WIDTH)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `num`  in  WIDTH  operand, captured on accepted start
- `amt`  in  AMT_W  shift amount, captured on accepted start
- `op`  in  2  00 SRL, 01 SLL, 10 SRA, 11 ROR (see Configuration)
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse, result valid
- `out`  out  WIDTH  registered result, held until next `done`

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, `start`=1:
  - Capture `acc<=num`, `cnt<=amt`, `op_q<=op`.
  - Go to DONE if `amt`==0, else go to SHIFT.
- SHIFT, each cycle:
  - Shift `acc` one position per `op_q`; `cnt<=cnt-1`.
  - Go to DONE when `cnt`==1 (the last step).
- Per-step rules:
  - SRL: shift in 0 at MSB.
  - SLL: shift in 0 at LSB.
  - SRA: replicate `acc[WIDTH-1]`.
  - ROR: `acc[0]` moves to MSB.
- DONE: `out<=acc`, `done`=1 for this cycle only, go to IDLE unconditionally.
- `start` while `busy`: ignored, no queuing. `num`/`amt`/`op` changes after capture have no effect.
- `start` in the same cycle DONE returns to IDLE: not accepted. A new request is accepted one cycle after `done`.
- Arithmetic: amounts are 0..31 only, never a full-width shift. Results are bit-exact with the combinational equivalents (`>>`, `<<`, `>>>`, rotate).

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `out`=0; `acc`, `cnt` cleared.
- Start accepted at edge E0. `done` is high in the cycle after edge E0+amt+1 (amt=0: the cycle after E0+1).
- Latency: amt+2 edges from start to `done` falling; `busy` high for amt+1 cycles.
- `out` updates only on the edge entering the `done` cycle and is stable otherwise.
- Reset asserted mid-operation: immediate return to reset values, no `done`, partial result discarded.
- Throughput: one operation per amt+2 cycles.

## Configuration
- `SHIFT_SEQ_ROT_EN` defined: op 11 performs rotate-right.
- `SHIFT_SEQ_ROT_EN` undefined: rotate logic is absent and op 11 behaves exactly as SRL. Timing is identical in both builds.

## Structure
- Shared package `shift_pkg` holds:
  - Op encodings `OP_SRL`=2'b00, `OP_SLL`=2'b01, `OP_SRA`=2'b10, `OP_ROR`=2'b11.
  - State encoding IDLE/SHIFT/DONE.
  - `WIDTH`/`AMT_W` defaults.
- Sub-module `shift_step`: combinational single-position step (`acc`, `op_q` → next `acc`), including the rotate arm under the macro.
- Top level `shift_seq` holds the FSM, counter and registers.

## Test plan
- Reset, then idle 5 cycles → `busy`=0, `done`=0, `out`=0.
- `num`=32'h0000_00F0, `amt`=4, op SLL, 1-cycle start → `busy` for 5 cycles; `done` pulse 6 edges after start; `out`=32'h0000_0F00.
- `num`=32'h8000_0000, `amt`=31, op SRA → `out`=32'hFFFF_FFFF after 33 edges. Same operand with op SRL → `out`=32'h0000_0001.
- `amt`=0, op SRL, `num`=32'hDEAD_BEEF → `done` 2 edges after start; `out`=32'hDEAD_BEEF.
- op ROR, `num`=32'h0000_0001, `amt`=1:
  - With macro: `out`=32'h8000_0000.
  - Without macro: `out`=32'h0000_0000.
- Start with `amt`=8; pulse `start` with new data mid-run → ignored, original result delivered. Separately, assert `rst` at cycle 3 of a run → no `done`, outputs at reset values.
